// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;

  // Which requester owns the transaction in flight
  typedef enum logic {SRC_IF, SRC_D} arb_src_t;

  // Longest memory latency the wait counter must be able to hold
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_picker.sv
// Priority pick between fetch and data requesters, with a starvation
// counter that forces a fetch grant after STARVE_MAX data grants in a row.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     arb_en,
  input  logic     if_req,
  input  logic     d_req,
  output logic     pick_valid,
  output arb_src_t pick_src
);

  localparam int CW = 4;

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = if_req && (starve_cnt == CW'(STARVE_MAX));

  // Data wins unless fetch has waited through STARVE_MAX data grants
  always_comb begin
    pick_valid = if_req | d_req;
    pick_src   = SRC_IF;
    if (d_req && !starved) begin
      pick_src = SRC_D;
    end
  end

  // Count data grants that leave a fetch waiting; any other grant clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en && pick_valid) begin
      if ((pick_src == SRC_IF) || !if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction at a time: latch the winner, strobe memory for one cycle,
// wait out the read latency, then hand the data back to the owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_R,
  output logic          mem_W,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_Din,
  input  logic [DW-1:0] mem_Dout,
  output logic          busy
);

  arb_state_t           state_q, state_d;
  arb_src_t             src_q;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;
  logic [DW-1:0]        rdata_q;
  logic [LAT_CNT_W-1:0] lat_q;
  logic                 arb_en;
  logic                 pick_valid;
  arb_src_t             pick_src;

  assign arb_en = (state_q == ARB_IDLE);

  mem_arb_picker #(
    .STARVE_MAX(STARVE_MAX)
  ) u_picker (
    .clk       (clk),
    .reset     (reset),
    .arb_en    (arb_en),
    .if_req    (if_req),
    .d_req     (d_req),
    .pick_valid(pick_valid),
    .pick_src  (pick_src)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning request while idle; the loser simply keeps waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= SRC_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (arb_en && pick_valid) begin
      src_q <= pick_src;
      if (pick_src == SRC_D) begin
        we_q    <= d_we;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end else begin
        we_q   <= 1'b0;
        addr_q <= if_addr;
      end
    end
  end

  // Latency down-counter; read data is captured on the last wait cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_q   <= '0;
      rdata_q <= '0;
    end else if (state_q == ARB_ISSUE) begin
      lat_q <= LAT_CNT_W'(MEM_LAT);
    end else if (state_q == ARB_WAIT) begin
      lat_q <= lat_q - LAT_CNT_W'(1);
      if (lat_q == LAT_CNT_W'(1)) begin
        rdata_q <= mem_Dout;
      end
    end
  end

  // Next state and per-state strobes; writes skip the wait and response
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_R     = 1'b0;
    mem_W     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) state_d = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        if_gnt  = (src_q == SRC_IF);
        d_gnt   = (src_q == SRC_D);
        mem_R   = !we_q;
        mem_W   = we_q;
        state_d = we_q ? ARB_IDLE : ARB_WAIT;
      end
      ARB_WAIT: begin
        if (lat_q == LAT_CNT_W'(1)) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if_rvalid = (src_q == SRC_IF);
        d_rvalid  = (src_q == SRC_D);
        state_d   = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign if_rdata    = rdata_q;
  assign d_rdata     = rdata_q;
  assign mem_address = addr_q;
  assign mem_Din     = wdata_q;
  assign busy        = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LAT_A       = 1;
  localparam int LAT_B       = 3;
  localparam int STARVE      = 4;
  localparam int RAND_CYCLES = 400;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_r, mem_w, busy;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_din, mem_dout;

  logic        if_req_b;
  logic [31:0] if_addr_b;
  logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_r_b, mem_w_b, busy_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_address_b, mem_din_b, mem_dout_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  int          left_a = 0;
  int          left_b = 0;
  logic [31:0] pend_a = 32'h0;
  logic [31:0] pend_b = 32'h0;

  logic [31:0] ref_mem [logic [31:0]];

  int checks   = 0;
  int failures = 0;

  // Free-running clock
  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_A), .STARVE_MAX(STARVE)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_R(mem_r), .mem_W(mem_w), .mem_address(mem_address), .mem_Din(mem_din),
    .mem_Dout(mem_dout), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_B), .STARVE_MAX(STARVE)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .mem_R(mem_r_b), .mem_W(mem_w_b), .mem_address(mem_address_b), .mem_Din(mem_din_b),
    .mem_Dout(mem_dout_b), .busy(busy_b)
  );

  // Memory contents start cleared, with one known word for the slow instance
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_b[0] = 32'h00C0FFEE;
  end

  // Memory A: read data shows garbage until the latency has elapsed
  always @(posedge clk) begin
    if (mem_w) mem_a[mem_address[9:2]] = mem_din;
    if (mem_r) begin
      pend_a = mem_a[mem_address[9:2]];
      left_a = LAT_A - 1;
    end else if (left_a > 0) begin
      left_a = left_a - 1;
    end
    mem_dout <= (left_a == 0) ? pend_a : 32'hBAD0BAD0;
  end

  // Memory B: same model with the longer latency
  always @(posedge clk) begin
    if (mem_w_b) mem_b[mem_address_b[9:2]] = mem_din_b;
    if (mem_r_b) begin
      pend_b = mem_b[mem_address_b[9:2]];
      left_b = LAT_B - 1;
    end else if (left_b > 0) begin
      left_b = left_b - 1;
    end
    mem_dout_b <= (left_b == 0) ? pend_b : 32'hBAD0BAD0;
  end

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset    = 1'b1;
    if_req   = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    if_req_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00400010; d_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_pre_gnt: got %b expected 1", d_gnt);
    end
    d_req = 1'b0; reset = 1'b1;
    ref_mem[32'h00400010] = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_r, mem_w, busy} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_r, mem_w, busy});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      failures++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0", if_rdata, d_rdata);
    end
    checks++;
    if ({mem_address, mem_din} !== 64'h0) begin
      failures++; $display("[TB] FAIL reset_latches: got %h/%h expected 0", mem_address, mem_din);
    end
    checks++;
    if ({if_gnt_b, if_rvalid_b, mem_r_b, mem_w_b, busy_b, mem_address_b} !== 37'h0) begin
      failures++; $display("[TB] FAIL reset_dut_b: got busy=%b addr=%h expected 0", busy_b, mem_address_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch_after_write();
    logic [3:0]  gnt_seen, rv_seen, drv_seen;
    logic [31:0] data3;
    applyReset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00400000; d_wdata = 32'h00100413;
    @(negedge clk);
    checks++;
    if ({d_gnt, mem_w, mem_r} !== 3'b110) begin
      failures++; $display("[TB] FAIL wr_issue: got %b expected 110", {d_gnt, mem_w, mem_r});
    end
    checks++;
    if ({mem_address, mem_din} !== {32'h00400000, 32'h00100413}) begin
      failures++; $display("[TB] FAIL wr_bus: got %h/%h expected 00400000/00100413", mem_address, mem_din);
    end
    d_req = 1'b0;
    ref_mem[32'h00400000] = 32'h00100413;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL wr_done_idle: got %b expected 0", busy);
    end
    if_req = 1'b1; if_addr = 32'h00400000;
    gnt_seen = '0; rv_seen = '0; drv_seen = '0; data3 = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      gnt_seen[k-1] = if_gnt; rv_seen[k-1] = if_rvalid; drv_seen[k-1] = d_rvalid;
      if (k == 3) data3 = if_rdata;
      if (if_gnt) if_req = 1'b0;
    end
    checks++;
    if (gnt_seen !== 4'b0001) begin
      failures++; $display("[TB] FAIL fetch_gnt_timing: got %b expected 0001", gnt_seen);
    end
    checks++;
    if (rv_seen !== 4'b0100) begin
      failures++; $display("[TB] FAIL fetch_rvalid_timing: got %b expected 0100", rv_seen);
    end
    checks++;
    if (drv_seen !== 4'b0000) begin
      failures++; $display("[TB] FAIL fetch_no_d_rvalid: got %b expected 0000", drv_seen);
    end
    checks++;
    if (data3 !== 32'h00100413) begin
      failures++; $display("[TB] FAIL fetch_rdata: got %h expected 00100413", data3);
    end
  endtask

  task automatic test_priority();
    logic [7:0]  ig, dg, ir, dr;
    logic [31:0] idata, ddata;
    applyReset();
    if_req = 1'b1; if_addr = 32'h00400000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00400000;
    ig = '0; dg = '0; ir = '0; dr = '0; idata = 32'h0; ddata = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ig[k-1] = if_gnt; dg[k-1] = d_gnt; ir[k-1] = if_rvalid; dr[k-1] = d_rvalid;
      if (if_rvalid) idata = if_rdata;
      if (d_rvalid) ddata = d_rdata;
      if (if_gnt) if_req = 1'b0;
      if (d_gnt) d_req = 1'b0;
    end
    checks++;
    if ({dg, dr} !== {8'b00000001, 8'b00000100}) begin
      failures++; $display("[TB] FAIL prio_data_first: got gnt=%b rv=%b expected 00000001/00000100", dg, dr);
    end
    checks++;
    if ({ig, ir} !== {8'b00010000, 8'b01000000}) begin
      failures++; $display("[TB] FAIL prio_fetch_next: got gnt=%b rv=%b expected 00010000/01000000", ig, ir);
    end
    checks++;
    if ({ddata, idata} !== {32'h00100413, 32'h00100413}) begin
      failures++; $display("[TB] FAIL prio_rdata: got %h/%h expected 00100413/00100413", ddata, idata);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] seq;
    int         n;
    applyReset();
    seq = '0; n = 0;
    if_req = 1'b1; if_addr = 32'h00400000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00400100; d_wdata = $urandom();
    for (int k = 0; k < 80 && n < 10; k++) begin
      @(negedge clk);
      if (d_gnt) begin
        seq[n] = 1'b1; n++;
        ref_mem[d_addr] = d_wdata;
        d_addr = 32'h00400100 + 32'(4 * (n % 4));
        d_wdata = $urandom();
      end else if (if_gnt) begin
        seq[n] = 1'b0; n++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n != 10) begin
      failures++; $display("[TB] FAIL starve_grant_count: got %0d expected 10 within cycle budget", n);
    end
    checks++;
    if (seq !== 10'b0111101111) begin
      failures++; $display("[TB] FAIL starve_order: got %b expected 0111101111 (1=data, lsb first)", seq);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  gnt_seen, rv_seen;
    logic [31:0] data3;
    applyReset();
    if_req = 1'b1; if_addr = 32'h00400000;
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL midrst_in_wait: got busy=%b expected 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, if_rvalid, mem_r, mem_w} !== 4'b0000) begin
      failures++; $display("[TB] FAIL midrst_abort: got %b expected 0000", {busy, if_rvalid, mem_r, mem_w});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, if_rvalid} !== 2'b00) begin
      failures++; $display("[TB] FAIL midrst_stays_idle: got %b expected 00", {busy, if_rvalid});
    end
    if_req = 1'b1;
    gnt_seen = '0; rv_seen = '0; data3 = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      gnt_seen[k-1] = if_gnt; rv_seen[k-1] = if_rvalid;
      if (k == 3) data3 = if_rdata;
      if (if_gnt) if_req = 1'b0;
    end
    checks++;
    if ({gnt_seen, rv_seen} !== {4'b0001, 4'b0100}) begin
      failures++; $display("[TB] FAIL midrst_reissue: got gnt=%b rv=%b expected 0001/0100", gnt_seen, rv_seen);
    end
    checks++;
    if (data3 !== ref_read(32'h00400000)) begin
      failures++; $display("[TB] FAIL midrst_rdata: got %h expected %h", data3, ref_read(32'h00400000));
    end
  endtask

  task automatic test_write_read();
    logic [5:0]  gnt_seen, rv_seen, strobe_seen;
    logic [31:0] ddata;
    int          ngnt;
    bit          both;
    applyReset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00400004; d_wdata = 32'hDEADBEEF;
    gnt_seen = '0; rv_seen = '0; strobe_seen = '0; ddata = 32'h0; ngnt = 0; both = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      gnt_seen[k-1] = d_gnt; rv_seen[k-1] = d_rvalid; strobe_seen[k-1] = mem_r | mem_w;
      if (mem_r && mem_w) both = 1'b1;
      if (d_rvalid) ddata = d_rdata;
      if (d_gnt) begin
        ngnt++;
        if (ngnt == 1) begin
          ref_mem[32'h00400004] = 32'hDEADBEEF;
          d_we = 1'b0;
        end else begin
          d_req = 1'b0;
        end
      end
    end
    checks++;
    if ({gnt_seen, rv_seen} !== {6'b000101, 6'b010000}) begin
      failures++; $display("[TB] FAIL wr_rd_timing: got gnt=%b rv=%b expected 000101/010000", gnt_seen, rv_seen);
    end
    checks++;
    if (ddata !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL wr_rd_data: got %h expected deadbeef", ddata);
    end
    checks++;
    if ({both, strobe_seen} !== {1'b0, 6'b000101}) begin
      failures++; $display("[TB] FAIL wr_rd_strobes: got both=%b strobes=%b expected 0/000101", both, strobe_seen);
    end
  endtask

  task automatic test_latency3();
    logic [7:0]  busy_seen, gnt_seen, rv_seen, rd_seen, other_seen;
    logic [31:0] idata, ddata, addr1;
    applyReset();
    if_req_b = 1'b1; if_addr_b = 32'h00400000;
    busy_seen = '0; gnt_seen = '0; rv_seen = '0; rd_seen = '0; other_seen = '0;
    idata = 32'h0; ddata = 32'h0; addr1 = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      busy_seen[k-1] = busy_b; gnt_seen[k-1] = if_gnt_b; rv_seen[k-1] = if_rvalid_b;
      rd_seen[k-1] = mem_r_b; other_seen[k-1] = d_gnt_b | d_rvalid_b | mem_w_b;
      if (k == 1) addr1 = mem_address_b;
      if (if_rvalid_b) begin idata = if_rdata_b; ddata = d_rdata_b; end
      if (if_gnt_b) if_req_b = 1'b0;
    end
    checks++;
    if (busy_seen !== 8'b00011111) begin
      failures++; $display("[TB] FAIL lat3_busy: got %b expected 00011111", busy_seen);
    end
    checks++;
    if ({gnt_seen, rd_seen, rv_seen} !== {8'b00000001, 8'b00000001, 8'b00010000}) begin
      failures++; $display("[TB] FAIL lat3_timing: got gnt=%b rd=%b rv=%b expected 00000001/00000001/00010000", gnt_seen, rd_seen, rv_seen);
    end
    checks++;
    if (other_seen !== 8'b0) begin
      failures++; $display("[TB] FAIL lat3_data_side_quiet: got %b expected 00000000", other_seen);
    end
    checks++;
    if ({idata, ddata, addr1, mem_din_b} !== {32'h00C0FFEE, 32'h00C0FFEE, 32'h00400000, 32'h0}) begin
      failures++; $display("[TB] FAIL lat3_data: got %h/%h addr=%h din=%h expected 00c0ffee/00c0ffee/00400000/0", idata, ddata, addr1, mem_din_b);
    end
  endtask

  task automatic test_random();
    int          idle_from, starve, gnt_cyc, rv_cyc;
    bit          if_pend, d_pend, gnt_d, gnt_we, rv_d, win_d;
    logic [31:0] gnt_addr, gnt_wd, rv_data, got;
    logic [1:0]  exp2, got2;
    applyReset();
    idle_from = 0; starve = 0; gnt_cyc = -1; rv_cyc = -1;
    if_pend = 0; d_pend = 0; gnt_d = 0; gnt_we = 0; rv_d = 0;
    gnt_addr = 32'h0; gnt_wd = 32'h0; rv_data = 32'h0;
    for (int t = 0; t < RAND_CYCLES + 24; t++) begin
      if (t > 0) @(negedge clk);
      exp2 = {t == gnt_cyc && !gnt_d, t == gnt_cyc && gnt_d};
      got2 = {if_gnt, d_gnt};
      checks++;
      if (got2 !== exp2) begin
        failures++; $display("[TB] FAIL rand_gnt t=%0d: got if/d=%b expected %b", t, got2, exp2);
      end
      exp2 = {t == gnt_cyc && !gnt_we, t == gnt_cyc && gnt_we};
      got2 = {mem_r, mem_w};
      checks++;
      if (got2 !== exp2) begin
        failures++; $display("[TB] FAIL rand_strobe t=%0d: got R/W=%b expected %b", t, got2, exp2);
      end
      if (t == gnt_cyc) begin
        checks++;
        if (mem_address !== gnt_addr) begin
          failures++; $display("[TB] FAIL rand_addr t=%0d: got %h expected %h", t, mem_address, gnt_addr);
        end
        if (gnt_we) begin
          checks++;
          if (mem_din !== gnt_wd) begin
            failures++; $display("[TB] FAIL rand_din t=%0d: got %h expected %h", t, mem_din, gnt_wd);
          end
        end
      end
      exp2 = {t == rv_cyc && !rv_d, t == rv_cyc && rv_d};
      got2 = {if_rvalid, d_rvalid};
      checks++;
      if (got2 !== exp2) begin
        failures++; $display("[TB] FAIL rand_rvalid t=%0d: got if/d=%b expected %b", t, got2, exp2);
      end
      if (t == rv_cyc) begin
        got = rv_d ? d_rdata : if_rdata;
        checks++;
        if (got !== rv_data) begin
          failures++; $display("[TB] FAIL rand_rdata t=%0d: got %h expected %h", t, got, rv_data);
        end
      end
      checks++;
      if (busy !== (t < idle_from)) begin
        failures++; $display("[TB] FAIL rand_busy t=%0d: got %b expected %b", t, busy, (t < idle_from));
      end

      if (t == gnt_cyc) begin
        if (gnt_d) d_pend = 0;
        else if_pend = 0;
      end
      if (t < RAND_CYCLES) begin
        if (!if_pend && $urandom_range(99) < 35) begin
          if_pend = 1;
          if_addr = 32'h00400200 + 32'(4 * $urandom_range(7));
        end
        if (!d_pend && $urandom_range(99) < 45) begin
          d_pend  = 1;
          d_we    = 1'($urandom_range(1));
          d_addr  = 32'h00400200 + 32'(4 * $urandom_range(7));
          d_wdata = $urandom();
        end
      end
      if_req = if_pend;
      d_req  = d_pend;

      if (t >= idle_from && (if_pend || d_pend)) begin
        win_d = d_pend && !(if_pend && starve == STARVE);
        if (win_d && if_pend) starve = (starve < STARVE) ? starve + 1 : STARVE;
        else starve = 0;
        gnt_cyc  = t + 1;
        gnt_d    = win_d;
        gnt_we   = win_d && d_we;
        gnt_addr = win_d ? d_addr : if_addr;
        gnt_wd   = d_wdata;
        if (gnt_we) begin
          ref_mem[gnt_addr] = gnt_wd;
          idle_from = t + 2;
        end else begin
          rv_cyc    = t + 2 + LAT_A;
          rv_d      = win_d;
          rv_data   = ref_read(gnt_addr);
          idle_from = t + 3 + LAT_A;
        end
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    if_req_b = 1'b0; if_addr_b = 32'h0;
    test_reset();
    test_fetch_after_write();
    test_priority();
    test_starvation();
    test_reset_mid();
    test_write_read();
    test_latency3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
